// File: rtl/fp_gt.sv
// Registered IEEE-754 binary32 comparator: gt/lt/eq/unordered flags with
// optional input register stage and optional denormals-are-zero handling.
module fp_gt #(
  parameter bit IN_REG = 1'b0,
  parameter bit DAZ    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] f1,
  input  logic [31:0] f2,
  output logic        out,
  output logic        lt,
  output logic        eq,
  output logic        unordered,
  output logic        out_valid
);

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_valid;

  generate
    if (IN_REG) begin : g_inReg
      logic [31:0] r_a;
      logic [31:0] r_b;
      logic        r_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a     <= '0;
          r_b     <= '0;
          r_valid <= 1'b0;
        end else begin
          r_a     <= f1;
          r_b     <= f2;
          r_valid <= in_valid;
        end
      end

      assign w_a     = r_a;
      assign w_b     = r_b;
      assign w_valid = r_valid;
    end else begin : g_noInReg
      assign w_a     = f1;
      assign w_b     = f2;
      assign w_valid = in_valid;
    end
  endgenerate

  logic w_nanA;
  logic w_nanB;
  logic w_zeroA;
  logic w_zeroB;
  logic w_magGt;
  logic w_magEq;

  // With DAZ a subnormal counts as a signed zero, so the zero class absorbs any mantissa.
  assign w_nanA  = (&w_a[30:23]) && (|w_a[22:0]);
  assign w_nanB  = (&w_b[30:23]) && (|w_b[22:0]);
  assign w_zeroA = (w_a[30:23] == 8'h00) && (DAZ || (w_a[22:0] == 23'h0));
  assign w_zeroB = (w_b[30:23] == 8'h00) && (DAZ || (w_b[22:0] == 23'h0));

  // A flushed subnormal is still smaller in raw bits than any normal, so masking keeps compares exact.
  logic [30:0] w_magA;
  logic [30:0] w_magB;
  assign w_magA  = w_zeroA ? 31'h0 : w_a[30:0];
  assign w_magB  = w_zeroB ? 31'h0 : w_b[30:0];
  assign w_magGt = w_magA > w_magB;
  assign w_magEq = w_magA == w_magB;

  logic w_gt;
  logic w_lt;
  logic w_eq;
  logic w_un;

  always_comb begin
    w_gt = 1'b0;
    w_lt = 1'b0;
    w_eq = 1'b0;
    w_un = 1'b0;
    if (w_nanA || w_nanB) begin
      w_un = 1'b1;
    end else if (w_zeroA && w_zeroB) begin
      w_eq = 1'b1;
    end else if (w_a[31] != w_b[31]) begin
      w_gt = ~w_a[31];
      w_lt = w_a[31];
    end else if (w_magEq) begin
      w_eq = 1'b1;
    end else if (w_magGt ^ w_a[31]) begin
      w_gt = 1'b1;
    end else begin
      w_lt = 1'b1;
    end
  end

  logic r_gt;
  logic r_lt;
  logic r_eq;
  logic r_un;
  logic r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
      r_un    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_gt    <= w_gt;
      r_lt    <= w_lt;
      r_eq    <= w_eq;
      r_un    <= w_un;
      r_valid <= w_valid;
    end
  end

  assign out       = r_gt;
  assign lt        = r_lt;
  assign eq        = r_eq;
  assign unordered = r_un;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_fp_gt.sv
// Self-checking bench for fp_gt: three configurations driven in parallel and
// checked against a real-number reference model with a per-config delay line.
module tb_fp_gt;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] f1;
  logic [31:0] f2;

  localparam int NDUT = 3;
  logic [4:0] obs [NDUT];
  int lat [NDUT] = '{1, 2, 1};
  bit dazOf [NDUT] = '{1'b0, 1'b0, 1'b1};

  int evaluated = 0;
  int failures  = 0;

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [31:0] b;
  } beat_t;

  beat_t hist [$];

  logic o0, l0, e0, u0, v0;
  logic o1, l1, e1, u1, v1;
  logic o2, l2, e2, u2, v2;

  fp_gt #(.IN_REG(1'b0), .DAZ(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .f1(f1), .f2(f2),
    .out(o0), .lt(l0), .eq(e0), .unordered(u0), .out_valid(v0));
  fp_gt #(.IN_REG(1'b1), .DAZ(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .f1(f1), .f2(f2),
    .out(o1), .lt(l1), .eq(e1), .unordered(u1), .out_valid(v1));
  fp_gt #(.IN_REG(1'b0), .DAZ(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .f1(f1), .f2(f2),
    .out(o2), .lt(l2), .eq(e2), .unordered(u2), .out_valid(v2));

  assign obs[0] = {o0, l0, e0, u0, v0};
  assign obs[1] = {o1, l1, e1, u1, v1};
  assign obs[2] = {o2, l2, e2, u2, v2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Infinity maps to a value far beyond the binary32 range; NaN is reported separately.
  function automatic real toReal(input logic [31:0] f, input bit daz, output bit nan);
    int  e;
    int  m;
    real mag;
    e   = int'(f[30:23]);
    m   = int'(f[22:0]);
    nan = (e == 255) && (m != 0);
    if (e == 255)      mag = 1.0e300;
    else if (e == 0)   mag = daz ? 0.0 : real'(m) * (2.0 ** (-149.0));
    else               mag = real'(m + 8388608) * (2.0 ** real'(e - 150));
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [3:0] refCompare(input logic [31:0] a, input logic [31:0] b, input bit daz);
    bit  na, nb;
    real ra, rb;
    ra = toReal(a, daz, na);
    rb = toReal(b, daz, nb);
    if (na || nb) return 4'b0001;
    if (ra > rb)  return 4'b1000;
    if (ra < rb)  return 4'b0100;
    return 4'b0010;
  endfunction

  task automatic checkOutputs();
    logic [4:0] expv;
    for (int d = 0; d < NDUT; d++) begin
      if (hist.size() >= lat[d] && hist[lat[d]-1].v) begin
        expv = {refCompare(hist[lat[d]-1].a, hist[lat[d]-1].b, dazOf[d]), 1'b1};
        evaluated++;
        assert (obs[d] === expv) else begin
          failures++;
          $error("[TB] FAIL result dut%0d a=%h b=%h observed=%b expected=%b",
                 d, hist[lat[d]-1].a, hist[lat[d]-1].b, obs[d], expv);
        end
        evaluated++;
        assert ($countones(obs[d][4:1]) == 1) else begin
          failures++;
          $error("[TB] FAIL onehot dut%0d observed=%b expected=one flag set", d, obs[d][4:1]);
        end
      end else begin
        evaluated++;
        assert (obs[d][0] === 1'b0) else begin
          failures++;
          $error("[TB] FAIL idle_valid dut%0d observed=%b expected=0", d, obs[d][0]);
        end
      end
    end
  endtask

  task automatic checkReset(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      evaluated++;
      assert (obs[d] === 5'b00000) else begin
        failures++;
        $error("[TB] FAIL %s dut%0d observed=%b expected=00000", tag, d, obs[d]);
      end
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [31:0] b);
    beat_t bt;
    @(negedge clk);
    checkOutputs();
    in_valid = v;
    f1       = a;
    f2       = b;
    bt.v = v;
    bt.a = a;
    bt.b = b;
    hist.push_front(bt);
    if (hist.size() > 4) void'(hist.pop_back());
  endtask

  function automatic logic [31:0] randOperand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r = {r[31], 31'h0};
      1: r = {r[31], 8'hFF, 23'h0};
      2: r = {r[31], 8'hFF, r[22:0] | 23'h1};
      3: r = {r[31], 8'h00, r[22:0]};
      4: r = {r[31], 31'h7F7FFFFF};
      5: r = {r[31], 8'h7F, r[22:0]};
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    f1       = '0;
    f2       = '0;
    @(negedge clk);
    checkReset("reset_state");
    @(negedge clk);
    checkReset("reset_state");
    rst_n = 1'b1;

    // Directed pairs driven back to back.
    applyStimulus(1'b1, 32'h40400000, 32'h3F800000);
    applyStimulus(1'b1, 32'h3F800000, 32'h40400000);
    applyStimulus(1'b1, 32'hC0400000, 32'hBF800000);
    applyStimulus(1'b1, 32'h3F800000, 32'hC0000000);
    applyStimulus(1'b1, 32'h00000000, 32'h80000000);
    applyStimulus(1'b1, 32'h3F800000, 32'h3F800000);
    applyStimulus(1'b1, 32'h7F800000, 32'h7F7FFFFF);
    applyStimulus(1'b1, 32'h7FC00000, 32'h3F800000);
    applyStimulus(1'b1, 32'h3F800000, 32'h7FC00000);
    applyStimulus(1'b1, 32'h00000002, 32'h00000001);
    applyStimulus(1'b1, 32'hFF800000, 32'hFF7FFFFF);
    applyStimulus(1'b1, 32'h7F800000, 32'h7F800000);
    applyStimulus(1'b1, 32'h80000003, 32'h00000000);
    applyStimulus(1'b1, 32'h80000001, 32'h80000002);
    applyStimulus(1'b0, 32'h40400000, 32'h3F800000);
    applyStimulus(1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h40400000, 32'h3F800000);
    applyStimulus(1'b1, 32'h3F800000, 32'h40400000);

    // Asynchronous reset mid-stream discards everything in flight.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkReset("async_reset");
    hist.delete();
    in_valid = 1'b1;
    @(negedge clk);
    checkReset("reset_hold");
    @(negedge clk);
    checkReset("reset_hold");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'hC0000000, 32'h3F800000);
    applyStimulus(1'b1, 32'h00800000, 32'h007FFFFF);

    for (int i = 0; i < 400; i++) begin
      a = randOperand();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h80000000;
        default: b = randOperand();
      endcase
      applyStimulus(($urandom_range(0, 3) != 0), a, b);
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutputs();

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
